dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port `DataMem` word memory. It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/loader port) using round-robin arbitration. It converts byte and halfword stores into read-modify-write word sequences, and it extracts sub-word load data. It sits between the pipeline MEM stage and `DataMem`.

---
 rtl/dmem_arb_pkg.sv | 45 ++++
 rtl/dmem_lane_merge.sv | 45 ++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and lane helpers for the dmem_arbiter slice.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RESP,
        ST_RMW_RD,
        ST_WR,
        ST_ERR
    } state_e;

    function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lane;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Drops address bits below the access size so every lane is naturally aligned.
    function automatic logic [1:0] align_lane(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: align_lane = lane;
            SZ_HALF: align_lane = {lane[1], 1'b0};
            default: align_lane = 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Combinational byte-lane datapath: store merge into an old word and sub-word load extract.
module dmem_lane_merge
    import dmem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    size_e       sz;
    logic [3:0]  be;
    logic [31:0] placed;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        sz        = size_e'(size);
        be        = byte_en(sz, lane);
        placed    = store_data;
        merged    = old_word;
        extracted = '0;
        shifted   = old_word >> {lane, 3'b000};

        // Replicating the store data puts the right bytes under whichever lanes are enabled.
        case (sz)
            SZ_BYTE: placed = {4{store_data[7:0]}};
            SZ_HALF: placed = {2{store_data[15:0]}};
            default: placed = store_data;
        endcase

        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = placed[8*i +: 8];
        end

        case (sz)
            SZ_BYTE: extracted = {24'h0, shifted[7:0]};
            SZ_HALF: extracted = {16'h0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and RMW sequencer in front of single-port DataMem.
// Optional misalignment trapping with err_o is enabled by defining DMEM_ARB_ERR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic              req0_we_i,
    input  logic [1:0]        req0_size_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              req0_rvalid_o,
    output logic [DATA_W-1:0] req0_rdata_o,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic              req1_we_i,
    input  logic [1:0]        req1_size_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req1_rvalid_o,
    output logic [DATA_W-1:0] req1_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
`ifdef DMEM_ARB_ERR_EN
    output logic              err_o,
`endif
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state, state_nxt;
    logic              ptr;
    logic              grant0, grant1, accept, sel;
    logic              sel_we, sel_bad;
    size_e             sel_size_raw, sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              owner_q, we_q;
    size_e             size_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, word_q;
    logic [31:0]       merged, extracted;

    // ptr=1 favours req1; a lone valid requester wins regardless of ptr.
    always_comb begin
        grant0       = req0_valid_i && (!req1_valid_i || !ptr);
        grant1       = req1_valid_i && (!req0_valid_i || ptr);
        accept       = (state == ST_IDLE) && (grant0 || grant1);
        sel          = grant1;
        sel_we       = sel ? req1_we_i : req0_we_i;
        sel_size_raw = size_e'(sel ? req1_size_i : req0_size_i);
        sel_size     = (sel_size_raw == SZ_RSVD) ? SZ_WORD : sel_size_raw;
        sel_addr     = sel ? req1_addr_i : req0_addr_i;
        sel_wdata    = sel ? req1_wdata_i : req0_wdata_i;
`ifdef DMEM_ARB_ERR_EN
        sel_bad      = misaligned(sel_size, sel_addr[1:0]);
`else
        sel_bad      = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= 1'b0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            lane_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                ptr     <= ~sel;
                owner_q <= sel;
                we_q    <= sel_we;
                size_q  <= sel_size;
                lane_q  <= align_lane(sel_size, sel_addr[1:0]);
                addr_q  <= {sel_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= sel_wdata;
            end
            if (state == ST_RD || state == ST_RMW_RD) word_q <= mem_rdata_i;
        end
    end

    dmem_lane_merge u_lane_merge (
        .size       (size_q),
        .lane       (lane_q),
        .old_word   (word_q),
        .store_data (wdata_q),
        .merged     (merged),
        .extracted  (extracted)
    );

    always_comb begin
        state_nxt     = state;
        req0_ready_o  = 1'b0;
        req1_ready_o  = 1'b0;
        req0_rvalid_o = 1'b0;
        req1_rvalid_o = 1'b0;
        req0_rdata_o  = '0;
        req1_rdata_o  = '0;
        mem_re_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;

        case (state)
            ST_IDLE: begin
                req0_ready_o = grant0;
                req1_ready_o = grant1;
                if (accept) begin
                    if (sel_bad)                 state_nxt = ST_ERR;
                    else if (!sel_we)            state_nxt = ST_RD;
                    else if (sel_size == SZ_WORD) state_nxt = ST_WR;
                    else                         state_nxt = ST_RMW_RD;
                end
            end
            ST_RD, ST_RMW_RD: begin
                mem_re_o   = 1'b1;
                mem_addr_o = addr_q;
                state_nxt  = (state == ST_RD) ? ST_RESP : ST_WR;
            end
            ST_RESP: begin
                req0_rvalid_o = !owner_q;
                req1_rvalid_o = owner_q;
                req0_rdata_o  = owner_q ? '0 : extracted;
                req1_rdata_o  = owner_q ? extracted : '0;
                state_nxt     = ST_IDLE;
            end
            ST_WR: begin
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = merged;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DMEM_ARB_ERR_EN
    assign err_o = (state == ST_ERR);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural DataMem stand-in.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
    logic [1:0]  req0_size = 2'b00, req1_size = 2'b00;
    logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [31:0] req0_rdata, req1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;
    logic        err;

    logic [31:0] mem [0:15];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_we_i     (req0_we),
        .req0_size_i   (req0_size),
        .req0_addr_i   (req0_addr),
        .req0_wdata_i  (req0_wdata),
        .req0_rvalid_o (req0_rvalid),
        .req0_rdata_o  (req0_rdata),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_we_i     (req1_we),
        .req1_size_i   (req1_size),
        .req1_addr_i   (req1_addr),
        .req1_wdata_i  (req1_wdata),
        .req1_rvalid_o (req1_rvalid),
        .req1_rdata_o  (req1_rdata),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_re_o      (mem_re),
        .mem_we_o      (mem_we),
`ifdef DMEM_ARB_ERR_EN
        .err_o         (err),
`endif
        .mem_rdata_i   (mem_rdata)
    );

`ifndef DMEM_ARB_ERR_EN
    assign err = 1'b0;
`endif

    // DataMem model: synchronous write, combinational read while enabled.
    always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
    assign mem_rdata = mem_re ? mem[mem_addr[5:2]] : 32'h0;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvalid_of(input bit p);
        return p ? req1_rvalid : req0_rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input bit p);
        return p ? req1_rdata : req0_rdata;
    endfunction

    task automatic drive(input bit p, input logic v, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            req1_valid = v; req1_we = we; req1_size = size; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = v; req0_we = we; req0_size = size; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // Called at a falling edge; returns just after the accept edge with valid dropped.
    task automatic issue(input bit p, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        drive(p, 1'b1, we, size, addr, wdata);
        #1;
        while (!ready_of(p) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("accept_ready", {31'h0, ready_of(p)}, 32'h1);
        check("ready_exclusive", {31'h0, req0_ready & req1_ready}, 32'h0);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic run_load(input bit p, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] exp);
        issue(p, 1'b0, size, addr, 32'h0);
        @(negedge clk);
        check("ld_rd_phase_re", {31'h0, mem_re}, 32'h1);
        check("ld_no_early_rvalid", {31'h0, rvalid_of(p)}, 32'h0);
        @(negedge clk);
        check("ld_rvalid", {31'h0, rvalid_of(p)}, 32'h1);
        check("ld_other_rvalid", {31'h0, rvalid_of(!p)}, 32'h0);
        check("ld_rdata", rdata_of(p), exp);
    endtask

    task automatic run_store(input bit p, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
        issue(p, 1'b1, size, addr, wdata);
        @(negedge clk);
        if (size == 2'b00 || size == 2'b01) begin
            check("st_rmw_re", {30'h0, mem_re, mem_we}, 32'h2);
            @(negedge clk);
        end
        check("st_wr_we", {30'h0, mem_re, mem_we}, 32'h1);
        check("st_wr_addr", mem_addr, {addr[31:2], 2'b00});
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | req0_rvalid | req1_rvalid | mem_we;
        end
        check(name, {31'h0, seen}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 1, 2'b10, 32'h0, 32'h000000AE, 32'h0};
        vecs[1]  = '{0, 0, 2'b10, 32'h0, 32'h0, 32'h000000AE};
        vecs[2]  = '{1, 1, 2'b10, 32'h4, 32'h11223344, 32'h0};
        vecs[3]  = '{0, 1, 2'b00, 32'h6, 32'h123456DA, 32'h0};
        vecs[4]  = '{1, 0, 2'b10, 32'h4, 32'h0, 32'h11DA3344};
        vecs[5]  = '{0, 0, 2'b01, 32'h6, 32'h0, 32'h000011DA};
        vecs[6]  = '{1, 0, 2'b00, 32'h7, 32'h0, 32'h00000011};
        vecs[7]  = '{1, 1, 2'b01, 32'h2, 32'h0000BEEF, 32'h0};
        vecs[8]  = '{0, 0, 2'b10, 32'h0, 32'h0, 32'hBEEF00AE};
        vecs[9]  = '{0, 0, 2'b00, 32'h1, 32'h0, 32'h00000000};
        vecs[10] = '{0, 1, 2'b00, 32'h3, 32'h00000055, 32'h0};
        vecs[11] = '{1, 0, 2'b01, 32'h2, 32'h0, 32'h000055EF};
        vecs[12] = '{0, 1, 2'b11, 32'h8, 32'hCAFEF00D, 32'h0};
        vecs[13] = '{0, 0, 2'b11, 32'h8, 32'h0, 32'hCAFEF00D};
        vecs[14] = '{1, 0, 2'b00, 32'h4, 32'h0, 32'h00000044};
        vecs[15] = '{1, 1, 2'b10, 32'hC, 32'h01020304, 32'h0};
        vecs[16] = '{1, 0, 2'b10, 32'hC, 32'h0, 32'h01020304};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {req0_ready, req1_ready, req0_rvalid, req1_rvalid, mem_re, mem_we, err},
              32'h0);
        check("rst_mem_bus", mem_addr | mem_wdata | req0_rdata | req1_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_ready", {30'h0, req0_ready, req1_ready}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) run_store(vecs[i].port, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            else            run_load(vecs[i].port, vecs[i].size, vecs[i].addr, vecs[i].exp);
        end

        // Misaligned word store and half load
        @(negedge clk);
`ifdef DMEM_ARB_ERR_EN
        issue(0, 1'b1, 2'b10, 32'h2, 32'h99887766);
        @(negedge clk);
        check("mis_err_pulse", {30'h0, err, mem_we}, 32'h2);
        @(negedge clk);
        check("mis_err_gone", {30'h0, err, mem_we}, 32'h0);
        check("mis_mem_kept", mem[0], 32'h55EF00AE);
        issue(1, 1'b0, 2'b01, 32'h5, 32'h0);
        @(negedge clk);
        check("mis_ld_err", {31'h0, err}, 32'h1);
        expect_quiet("mis_ld_no_rvalid", 3);
`else
        run_store(0, 2'b10, 32'h2, 32'h99887766);
        @(negedge clk);
        check("forced_align_write", mem[0], 32'h99887766);
        run_load(1, 2'b01, 32'h5, 32'h00003344);
`endif

        // Reset during WR abandons the write
        @(negedge clk);
        issue(1, 1'b1, 2'b10, 32'hC, 32'hDEADBEEF);
        @(negedge clk);
        check("rst_wr_we_before", {31'h0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_wr_we_drop", {30'h0, mem_we, mem_re}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wr_mem_kept", mem[3], 32'h01020304);
        expect_quiet("rst_wr_quiet", 3);

        // Reset during RD suppresses rvalid
        issue(0, 1'b0, 2'b10, 32'h4, 32'h0);
        @(negedge clk);
        check("rst_rd_re_before", {31'h0, mem_re}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_rd_re_drop", {31'h0, mem_re}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("rst_rd_no_rvalid", 3);

        // Both requesters continuously valid right after reset: grants alternate from req0.
        begin
            int  grants = 0;
            bit  expect_port = 1'b0;
            drive(0, 1'b1, 1'b1, 2'b10, 32'h10, 32'hA0A0A0A0);
            drive(1, 1'b1, 1'b1, 2'b10, 32'h14, 32'hB1B1B1B1);
            for (int c = 0; c < 12; c++) begin
                #1;
                check("arb_exclusive", {31'h0, req0_ready & req1_ready}, 32'h0);
                if (req0_ready | req1_ready) begin
                    check("arb_order", {31'h0, req1_ready}, {31'h0, expect_port});
                    expect_port = !expect_port;
                    grants++;
                end
                if (c == 11) begin
                    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                end
                @(negedge clk);
            end
            check("arb_grant_count", grants, 32'd6);
            repeat (2) @(negedge clk);
            check("arb_mem_req0", mem[4], 32'hA0A0A0A0);
            check("arb_mem_req1", mem[5], 32'hB1B1B1B1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
